// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// clocks out one byte with odd parity on device clock falls and collects the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps_clk_in,
    input  logic       ps_dat_in,
    output logic       ps_clk_oe,
    output logic       ps_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          dat_low;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          sync_clk;
    logic          sync_dat;
    logic          fall;

    // Synchronizers preset high so an idle bus never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps_clk_in};
            dat_sync <= {dat_sync[0], ps_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign sync_clk = clk_sync[1];
    assign sync_dat = dat_sync[1];
    assign fall     = clk_prev & ~sync_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            dat_low <= 1'b0;
            ack_ok  <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg  <= tx_data;
                        parity <= ~^tx_data;
                        ack_ok <= 1'b0;
                        cnt    <= '0;
                        state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REQ, S_SEND: begin
                    // The first fall in REQ is edge 1; a fall always beats an expiring timeout.
                    if (fall) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= S_SEND;
                        if (bit_cnt < 4'd8) begin
                            dat_low <= ~shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            dat_low <= ~parity;
                        end else if (bit_cnt == 4'd9) begin
                            dat_low <= 1'b0;
                        end else begin
                            ack_ok  <= ~sync_dat;
                            dat_low <= 1'b0;
                            state   <= S_WAIT_IDLE;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= S_IDLE;
                        error   <= 1'b1;
                        ack_ok  <= 1'b0;
                        dat_low <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (sync_clk && sync_dat) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        state   <= S_IDLE;
                        error   <= 1'b1;
                        ack_ok  <= 1'b0;
                        dat_low <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line drives decode straight from reset-cleared state so reset releases them at once.
    assign tx_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign ps_clk_oe = (state == S_INHIBIT);
    assign ps_dat_oe = ((state == S_INHIBIT) && (cnt == INH_LAST)) ||
                       (state == S_REQ) ||
                       ((state == S_SEND) && dat_low);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain bus with a behavioural
// PS/2 device that clocks frames in, captures the bits and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps_clk_in, ps_dat_in, ps_clk_oe, ps_dat_oe;
    logic       busy, done, ack_ok, error;
    logic       dev_clk = 1'b0;
    logic       dev_dat = 1'b0;

    int checks = 0;
    int fails  = 0;

    assign ps_clk_in = ~(ps_clk_oe | dev_clk);
    assign ps_dat_in = ~(ps_dat_oe | dev_dat);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps_clk_in(ps_clk_in), .ps_dat_in(ps_dat_in),
        .ps_clk_oe(ps_clk_oe), .ps_dat_oe(ps_dat_oe), .busy(busy),
        .done(done), .ack_ok(ack_ok), .error(error)
    );

    always #5 clk = ~clk;

    // Bus monitor
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_starts = 0;
    int done_cyc = 0, err_cyc = 0, req_cyc = 0, rel_cyc = 0;
    int inh_run = 0, inh_len = 0, dat_rise_at = 0;
    logic last_ack = 1'b0, prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (done) begin done_cnt++; last_ack = ack_ok; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (done && error) both_cnt++;
        if (ps_clk_oe) begin
            if (!prev_clk_oe) begin inh_run = 1; inh_starts++; end
            else inh_run++;
            if (ps_dat_oe && !prev_dat_oe) dat_rise_at = inh_run;
        end
        if (!ps_clk_oe && prev_clk_oe) begin inh_len = inh_run; req_cyc = cyc; end
        prev_clk_oe = ps_clk_oe;
        prev_dat_oe = ps_dat_oe;
    end

    // Device model configuration / results
    logic        dev_ack = 1'b0;
    int          dev_hold = 0;
    int          dev_stop = -1;
    logic [7:0]  dev_byte = 8'h00;
    logic [10:0] dev_bits = '0;
    logic        dev_to = 1'b0;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic device();
        int k;
        dev_to = 1'b0;
        dev_bits = '0;
        k = 0;
        while (!ps_clk_oe && k < 100) begin wait_cycles(1); k++; end
        if (!ps_clk_oe) begin dev_to = 1'b1; return; end
        k = 0;
        while (ps_clk_oe && k < INH + 50) begin wait_cycles(1); k++; end
        if (ps_clk_oe) begin dev_to = 1'b1; return; end
        wait_cycles(5);
        dev_bits[0] = ps_dat_in;
        if (dev_stop == 0) return;
        for (int n = 1; n <= 11; n++) begin
            dev_clk = 1'b1;
            wait_cycles(HALF);
            if (n <= 10) dev_bits[n] = ps_dat_in;
            dev_clk = 1'b0;
            if (n == 10 && dev_ack) dev_dat = 1'b1;
            wait_cycles(HALF);
            if (n == dev_stop) return;
        end
        wait_cycles(dev_hold);
        dev_dat = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic pulse_request();
        tx_data = dev_byte;
        tx_valid = 1'b1;
        wait_cycles(1);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_drop: tx_ready=%b expected 0", tx_ready);
        end
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin wait_cycles(1); k++; end
        checks++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL done_wait: no done within bound");
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input logic ack, input int hold, input string nm);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_byte = d;
        dev_ack = ack;
        dev_hold = hold;
        dev_stop = -1;
        fork
            device();
            pulse_request();
        join
        wait_done(d0);
        wait_cycles(3);
        checks++;
        if (dev_to !== 1'b0) begin fails++; $display("FAIL %s dev_bound: device wait expired", nm); end
        checks++;
        if (dev_bits !== frame_of(d)) begin
            fails++; $display("FAIL %s bits: got %b expected %b", nm, dev_bits, frame_of(d));
        end
        checks++;
        if (inh_len !== INH) begin fails++; $display("FAIL %s inhibit_len: got %0d expected %0d", nm, inh_len, INH); end
        checks++;
        if (dat_rise_at !== INH) begin fails++; $display("FAIL %s start_rise: got %0d expected %0d", nm, dat_rise_at, INH); end
        checks++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL %s done_count: got %0d expected 1", nm, done_cnt - d0); end
        checks++;
        if (last_ack !== ack) begin fails++; $display("FAIL %s ack_ok: got %b expected %b", nm, last_ack, ack); end
        checks++;
        if (ack_ok !== ack) begin fails++; $display("FAIL %s ack_hold: got %b expected %b", nm, ack_ok, ack); end
        checks++;
        if (err_cnt !== e0) begin fails++; $display("FAIL %s no_error: got %0d errors expected 0", nm, err_cnt - e0); end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps_clk_oe !== 1'b0 || ps_dat_oe !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: ready=%b busy=%b clk_oe=%b dat_oe=%b expected 1 0 0 0",
                     nm, tx_ready, busy, ps_clk_oe, ps_dat_oe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        checks++;
        if ({tx_ready, busy, ps_clk_oe, ps_dat_oe, done, ack_ok, error} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_state: got %b expected 1000000",
                     {tx_ready, busy, ps_clk_oe, ps_dat_oe, done, ack_ok, error});
        end
        rst_n = 1'b1;
        wait_cycles(3);
        checks++;
        if (tx_ready !== 1'b1 || ps_clk_oe !== 1'b0) begin
            fails++; $display("FAIL reset_release: ready=%b clk_oe=%b expected 1 0", tx_ready, ps_clk_oe);
        end
    endtask

    task automatic test_basic();
        do_frame(8'hED, 1'b1, 0, "send_ED");
        do_frame(8'h00, 1'b0, 0, "send_00_noack");
    endtask

    task automatic test_timeout();
        int d0, e0, k;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_byte = 8'hFF;
        dev_stop = 0;
        fork
            device();
            pulse_request();
        join
        k = 0;
        while (err_cnt == e0 && k < TO + 200) begin wait_cycles(1); k++; end
        checks++;
        if (err_cnt == e0) begin fails++; $display("FAIL timeout_wait: no error within bound"); end
        checks++;
        if (err_cyc - req_cyc !== TO) begin
            fails++; $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - req_cyc, TO);
        end
        wait_cycles(5);
        checks++;
        if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_pulse: got %0d expected 1", err_cnt - e0); end
        checks++;
        if (done_cnt !== d0) begin fails++; $display("FAIL timeout_no_done: got %0d done pulses expected 0", done_cnt - d0); end
        checks++;
        if ({ps_clk_oe, ps_dat_oe, tx_ready, ack_ok} !== 4'b0010) begin
            fails++; $display("FAIL timeout_idle: got %b expected 0010", {ps_clk_oe, ps_dat_oe, tx_ready, ack_ok});
        end
        dev_stop = -1;
    endtask

    task automatic test_midframe_reset();
        dev_byte = 8'hF4;
        dev_ack = 1'b1;
        dev_hold = 0;
        dev_stop = 4;
        fork
            device();
            pulse_request();
        join
        // After edge 4 of 0xF4 the host drives D3 = 0, so data is pulled low.
        checks++;
        if (ps_dat_oe !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL midframe_pre: dat_oe=%b busy=%b expected 1 1", ps_dat_oe, busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ps_clk_oe !== 1'b0 || ps_dat_oe !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_release: clk_oe=%b dat_oe=%b busy=%b expected 0 0 0", ps_clk_oe, ps_dat_oe, busy);
        end
        dev_clk = 1'b0;
        dev_dat = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);
        checks++;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        do_frame(8'hF4, 1'b1, 0, "send_F4_after_reset");
    endtask

    task automatic test_busy_ignore();
        int d0, i0;
        d0 = done_cnt;
        i0 = inh_starts;
        dev_byte = 8'h55;
        dev_ack = 1'b1;
        dev_hold = 0;
        dev_stop = -1;
        fork
            device();
            begin
                pulse_request();
                wait_cycles(200);
                tx_data = 8'hAA;
                tx_valid = 1'b1;
                wait_cycles(1);
                tx_valid = 1'b0;
            end
        join
        wait_done(d0);
        wait_cycles(40);
        checks++;
        if (dev_bits !== frame_of(8'h55)) begin
            fails++; $display("FAIL busy_bits: got %b expected %b", dev_bits, frame_of(8'h55));
        end
        checks++;
        if (done_cnt - d0 !== 1 || inh_starts - i0 !== 1) begin
            fails++; $display("FAIL busy_ignore: done=%0d inhibits=%0d expected 1 1", done_cnt - d0, inh_starts - i0);
        end
        do_frame(8'hAA, 1'b1, 0, "send_AA");
    endtask

    task automatic test_hold_low();
        do_frame(8'hF3, 1'b1, 1000, "hold_low");
        checks++;
        if (done_cyc <= rel_cyc) begin
            fails++; $display("FAIL hold_done_delay: done cycle %0d expected after release %0d", done_cyc, rel_cyc);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic a;
        int h;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            h = $urandom_range(0, 60);
            do_frame(d, a, h, "random");
        end
        checks++;
        if (both_cnt !== 0) begin fails++; $display("FAIL done_error_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_midframe_reset();
        test_busy_ignore();
        test_hold_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
